// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES-128 decryption core: block width, FSM state
// encoding, forward and inverse S-boxes, the round-constant table and the
// GF(2^8) helpers used by InvMixColumns.
// Byte order throughout: byte 0 = bits [127:120], state is column-major.
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE,
    KEYEXP,
    ROUND,
    DONE
  } fsm_state_e;

  // Forward S-box. The high nibble selects a 16-byte row, the low nibble
  // shifts the wanted byte up to the top of that row.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [127:0] row;
    case (b[7:4])
      4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
      4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
      4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
      4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
      4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
      4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
      4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
      default: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
    endcase
    row = row << {b[3:0], 3'b000};
    return row[127:120];
  endfunction

  // Inverse S-box, same row/column lookup scheme as the forward table.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [127:0] row;
    case (b[7:4])
      4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
      4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
      4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
      4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
      4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
      4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
      4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
      4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
      4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
      4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
      4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
      4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
      4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
      4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
      4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
      default: row = 128'h172b047eba77d626e169146355210c7d;
    endcase
    row = row << {b[3:0], 3'b000};
    return row[127:120];
  endfunction

  // Round constant for key-schedule step i, placed in the top byte of a word.
  function automatic logic [31:0] rcon(input logic [3:0] i);
    logic [7:0] rc;
    case (i)
      4'd0: rc = 8'h01;
      4'd1: rc = 8'h02;
      4'd2: rc = 8'h04;
      4'd3: rc = 8'h08;
      4'd4: rc = 8'h10;
      4'd5: rc = 8'h20;
      4'd6: rc = 8'h40;
      4'd7: rc = 8'h80;
      4'd8: rc = 8'h1b;
      4'd9: rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h000000};
  endfunction

  // Multiply by x in GF(2^8), reducing by the AES polynomial on carry-out.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply by shift-and-add; with a constant b the
  // unused partial products fold away.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// ---------------------------------------------------------------------------
// aes_inv_round
// Combinational AES inverse round:
//   InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns
// InvMixColumns is bypassed when last_round is set.
// Ports:
//   state_in   [127:0] current state
//   round_key  [127:0] round key to add
//   last_round         skip InvMixColumns
//   state_out  [127:0] next state
// ---------------------------------------------------------------------------
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] state_in,
  input  logic [AES_BLOCK_W-1:0] round_key,
  input  logic                   last_round,
  output logic [AES_BLOCK_W-1:0] state_out
);

  // Element 0 of a [0:15] packed array lands on bits [127:120], matching
  // the byte numbering of the block.
  logic [0:15][7:0] in_b;
  logic [0:15][7:0] rk_b;
  logic [0:15][7:0] shr_b;
  logic [0:15][7:0] ark_b;
  logic [0:15][7:0] mix_b;

  assign in_b = state_in;
  assign rk_b = round_key;

  // Row r rotates right by r columns: the byte ending in column c came from
  // column (c - r) mod 4. Byte index is row + 4*column.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shr_b[r + 4 * c] = in_b[r + 4 * ((c - r + 4) % 4)];
      end
    end
  end

  // InvSubBytes and AddRoundKey are both bytewise.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      ark_b[i] = inv_sbox(shr_b[i]) ^ rk_b[i];
    end
  end

  // InvMixColumns on each column with the 0e/0b/0d/09 circulant matrix.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      mix_b[4*c + 0] = gf_mul(ark_b[4*c], 8'h0e) ^ gf_mul(ark_b[4*c+1], 8'h0b)
                     ^ gf_mul(ark_b[4*c+2], 8'h0d) ^ gf_mul(ark_b[4*c+3], 8'h09);
      mix_b[4*c + 1] = gf_mul(ark_b[4*c], 8'h09) ^ gf_mul(ark_b[4*c+1], 8'h0e)
                     ^ gf_mul(ark_b[4*c+2], 8'h0b) ^ gf_mul(ark_b[4*c+3], 8'h0d);
      mix_b[4*c + 2] = gf_mul(ark_b[4*c], 8'h0d) ^ gf_mul(ark_b[4*c+1], 8'h09)
                     ^ gf_mul(ark_b[4*c+2], 8'h0e) ^ gf_mul(ark_b[4*c+3], 8'h0b);
      mix_b[4*c + 3] = gf_mul(ark_b[4*c], 8'h0b) ^ gf_mul(ark_b[4*c+1], 8'h0d)
                     ^ gf_mul(ark_b[4*c+2], 8'h09) ^ gf_mul(ark_b[4*c+3], 8'h0e);
    end
  end

  assign state_out = last_round ? ark_b : mix_b;

endmodule

// File: rtl/aes_decrypt_core.sv
// ---------------------------------------------------------------------------
// aes_decrypt_core
// Iterative AES-128 decryption, one round per clock. After accepting a
// key/ciphertext pair it walks the key schedule forward for 10 cycles to
// reach round key 10, then runs ten inverse rounds while stepping the
// schedule backwards, and presents plaintext through a valid/ack handshake.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   validIn, ready  input handshake (accept on validIn & ready)
//   key, data       cipher key and ciphertext, sampled on accept
//   validOut, ack   output handshake (ack sampled only while validOut)
//   dataOut         registered plaintext, held after ack
// ---------------------------------------------------------------------------
module aes_decrypt_core
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   validIn,
  output logic                   ready,
  input  logic [AES_BLOCK_W-1:0] key,
  input  logic [AES_BLOCK_W-1:0] data,
  output logic                   validOut,
  input  logic                   ack,
  output logic [AES_BLOCK_W-1:0] dataOut
);

  fsm_state_e             fsm;
  fsm_state_e             next_fsm;
  logic [3:0]             cnt;
  logic [3:0]             next_cnt;
  logic [AES_BLOCK_W-1:0] key_reg;
  logic [AES_BLOCK_W-1:0] next_key;
  logic [AES_BLOCK_W-1:0] state_reg;
  logic [AES_BLOCK_W-1:0] next_state;
  logic [AES_BLOCK_W-1:0] data_out;
  logic [AES_BLOCK_W-1:0] next_data_out;
  logic [AES_BLOCK_W-1:0] fwd_key;
  logic [AES_BLOCK_W-1:0] inv_key;
  logic [AES_BLOCK_W-1:0] round_out;

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // One forward key-schedule step: round key i -> round key i+1.
  function automatic logic [127:0] fwd_expand(input logic [127:0] k, input logic [31:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = sub_word(rot_word(k[31:0])) ^ rc;
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // One backward key-schedule step: round key i+1 -> round key i. The old
  // w3 must be recovered first because the g() term was computed from it.
  function automatic logic [127:0] inv_expand(input logic [127:0] k, input logic [31:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_word(rot_word(w3)) ^ rc;
    return {w0, w1, w2, w3};
  endfunction

  // Both key steps are indexed by cnt: forward during KEYEXP (0..9) and
  // backward during ROUND (9..0), so the rcon used to go forward from key i
  // is the same one used to come back to it.
  assign fwd_key = fwd_expand(key_reg, rcon(cnt));
  assign inv_key = inv_expand(key_reg, rcon(cnt));

  aes_inv_round u_inv_round (
    .state_in   (state_reg),
    .round_key  (inv_key),
    .last_round (cnt == 4'd0),
    .state_out  (round_out)
  );

  // State register for the FSM and datapath. Reset discards any block in
  // flight and returns every output to its idle value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      cnt       <= 4'd0;
      key_reg   <= '0;
      state_reg <= '0;
      data_out  <= '0;
    end else begin
      fsm       <= next_fsm;
      cnt       <= next_cnt;
      key_reg   <= next_key;
      state_reg <= next_state;
      data_out  <= next_data_out;
    end
  end

  // Next-state logic. KEYEXP ends by applying round key 10 to the
  // ciphertext in the same cycle that produces it, so ROUND starts directly
  // with the first inverse round.
  always_comb begin
    next_fsm      = fsm;
    next_cnt      = cnt;
    next_key      = key_reg;
    next_state    = state_reg;
    next_data_out = data_out;
    case (fsm)
      IDLE: begin
        if (validIn) begin
          next_key   = key;
          next_state = data;
          next_cnt   = 4'd0;
          next_fsm   = KEYEXP;
        end
      end
      KEYEXP: begin
        next_key = fwd_key;
        if (cnt == 4'd9) begin
          next_state = state_reg ^ fwd_key;
          next_cnt   = 4'd9;
          next_fsm   = ROUND;
        end else begin
          next_cnt = cnt + 4'd1;
        end
      end
      ROUND: begin
        next_key   = inv_key;
        next_state = round_out;
        if (cnt == 4'd0) begin
          next_data_out = round_out;
          next_fsm      = DONE;
        end else begin
          next_cnt = cnt - 4'd1;
        end
      end
      DONE: begin
        if (ack) next_fsm = IDLE;
      end
      default: next_fsm = IDLE;
    endcase
  end

  assign ready    = (fsm == IDLE);
  assign validOut = (fsm == DONE);
  assign dataOut  = data_out;

endmodule

// File: tb/tb_aes_decrypt_core.sv
// ---------------------------------------------------------------------------
// tb_aes_decrypt_core
// Self-checking bench for aes_decrypt_core: a table of known-answer vectors
// plus hand-written sequences for the handshake, reset and throughput cases.
// ---------------------------------------------------------------------------
module tb_aes_decrypt_core;

  typedef struct {
    logic [127:0] key;
    logic [127:0] data;
    logic [127:0] expected;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         validIn;
  logic         ready;
  logic [127:0] key;
  logic [127:0] data;
  logic         validOut;
  logic         ack;
  logic [127:0] dataOut;

  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[4];

  always #5 clk = ~clk;

  aes_decrypt_core dut (
    .clk      (clk),
    .rst      (rst),
    .validIn  (validIn),
    .ready    (ready),
    .key      (key),
    .data     (data),
    .validOut (validOut),
    .ack      (ack),
    .dataOut  (dataOut)
  );

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one block for exactly one accepting edge.
  task automatic applyStimulus(input logic [127:0] k, input logic [127:0] d);
    key     = k;
    data    = d;
    validIn = 1'b1;
    tick();
    validIn = 1'b0;
  endtask

  // Count edges until validOut, bounded so a dead core cannot hang the run.
  task automatic waitValid(output int cycles);
    cycles = 0;
    while (!validOut && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  task automatic doAck();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    int lat;
    int bad;
    int n_acc;
    int n_out;
    int acc_cyc[3];
    logic accepting;

    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3925841d02dc09fbdc118597196a0b32,
                128'h3243f6a8885a308d313198a2e0370734};
    vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3ad77bb40d7a3660a89ecaf32466ef97,
                128'h6bc1bee22e409f96e93d7e117393172a};
    vecs[3] = '{128'h00000000000000000000000000000000,
                128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                128'h00000000000000000000000000000000};

    rst     = 1'b1;
    validIn = 1'b0;
    ack     = 1'b0;
    key     = '0;
    data    = '0;
    tick();
    tick();
    checkOutput("reset_ready", 128'(ready), 128'd1);
    checkOutput("reset_validOut", 128'(validOut), 128'd0);
    checkOutput("reset_dataOut", dataOut, 128'd0);
    rst = 1'b0;
    tick();

    // Known-answer table.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].key, vecs[i].data);
      checkOutput($sformatf("vec%0d_busy_ready", i), 128'(ready), 128'd0);
      waitValid(lat);
      checkOutput($sformatf("vec%0d_latency", i), 128'(lat), 128'd20);
      checkOutput($sformatf("vec%0d_dataOut", i), dataOut, vecs[i].expected);
      checkOutput($sformatf("vec%0d_done_ready", i), 128'(ready), 128'd0);
      doAck();
      checkOutput($sformatf("vec%0d_ack_validOut", i), 128'(validOut), 128'd0);
      checkOutput($sformatf("vec%0d_ack_ready", i), 128'(ready), 128'd1);
    end

    // FIPS-197 C.1 with internal key-schedule checkpoints.
    applyStimulus(vecs[0].key, vecs[0].data);
    repeat (10) tick();
    checkOutput("c1_round_key10", dut.key_reg, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    repeat (9) tick();
    checkOutput("c1_validOut_early", 128'(validOut), 128'd0);
    tick();
    checkOutput("c1_validOut_at20", 128'(validOut), 128'd1);
    checkOutput("c1_key_restored", dut.key_reg, vecs[0].key);
    checkOutput("c1_dataOut", dataOut, vecs[0].expected);
    doAck();

    // Hold off ack for 50 cycles while poking validIn.
    applyStimulus(vecs[1].key, vecs[1].data);
    waitValid(lat);
    checkOutput("hold_latency", 128'(lat), 128'd20);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      validIn = i[0];
      data    = {$urandom, $urandom, $urandom, $urandom};
      tick();
      if (validOut !== 1'b1 || ready !== 1'b0 || dataOut !== vecs[1].expected) bad++;
    end
    checkOutput("hold_stable_cycles_bad", 128'(bad), 128'd0);
    validIn = 1'b1;
    ack     = 1'b1;
    tick();
    validIn = 1'b0;
    ack     = 1'b0;
    checkOutput("hold_ack_validOut", 128'(validOut), 128'd0);
    checkOutput("hold_ack_ready", 128'(ready), 128'd1);
    checkOutput("hold_dataOut_retained", dataOut, vecs[1].expected);
    tick();
    checkOutput("hold_no_queued_accept", 128'(ready), 128'd1);

    // Reset in the middle of ROUND.
    applyStimulus(vecs[2].key, vecs[2].data);
    repeat (14) tick();
    checkOutput("midrst_cnt", 128'(dut.cnt), 128'd5);
    rst = 1'b1;
    #1;
    checkOutput("midrst_ready", 128'(ready), 128'd1);
    checkOutput("midrst_validOut", 128'(validOut), 128'd0);
    checkOutput("midrst_dataOut", dataOut, 128'd0);
    tick();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (validOut !== 1'b0 || ready !== 1'b1) bad++;
    end
    checkOutput("midrst_no_validOut_bad", 128'(bad), 128'd0);
    applyStimulus(vecs[1].key, vecs[1].data);
    waitValid(lat);
    checkOutput("midrst_next_latency", 128'(lat), 128'd20);
    checkOutput("midrst_next_dataOut", dataOut, vecs[1].expected);
    doAck();

    // Back-to-back with validIn held high and ack tied high.
    n_acc   = 0;
    n_out   = 0;
    ack     = 1'b1;
    validIn = 1'b1;
    key     = vecs[0].key;
    data    = vecs[0].data;
    for (int cyc = 0; cyc < 80; cyc++) begin
      accepting = ready && validIn;
      tick();
      if (accepting) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc < 3) begin
          key  = vecs[n_acc].key;
          data = vecs[n_acc].data;
        end else begin
          validIn = 1'b0;
        end
      end
      if (validOut) begin
        if (n_out < 3)
          checkOutput($sformatf("b2b_dataOut%0d", n_out), dataOut, vecs[n_out].expected);
        n_out++;
      end
    end
    validIn = 1'b0;
    ack     = 1'b0;
    checkOutput("b2b_accepts", 128'(n_acc), 128'd3);
    checkOutput("b2b_outputs", 128'(n_out), 128'd3);
    if (n_acc == 3) begin
      checkOutput("b2b_period1", 128'(acc_cyc[1] - acc_cyc[0]), 128'd22);
      checkOutput("b2b_period2", 128'(acc_cyc[2] - acc_cyc[1]), 128'd22);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_decrypt_core.md
# aes_decrypt_core

Iterative AES-128 decryption core: the inverse of the unrolled encryption datapath, sharing its byte ordering (byte 0 = bits [127:120], column-major state, words w0..w3 = [127:96]..[31:0]). It accepts a 128-bit cipher key and a 128-bit ciphertext block, derives round key 10 by forward expansion, then runs ten inverse rounds while stepping the key schedule backwards, one round per clock. It sits beside the encryption core in the crypto subsystem and returns plaintext through a valid/ack handshake.

## Interface
- No parameters. Key length fixed at 128 bits.
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- validIn  input  1  key/data valid; accepted when validIn & ready at a rising edge
- ready  output  1  core is in IDLE and will accept a block
- key  input  128  cipher key (round key 0), sampled on accept
- data  input  128  ciphertext, sampled on accept
- validOut  output  1  dataOut holds a finished plaintext
- ack  input  1  consumer has taken dataOut; sampled only while validOut=1
- dataOut  output  128  plaintext, registered

## Operation
- FSM states: IDLE, KEYEXP, ROUND, DONE.
- IDLE: ready=1. On validIn: keyReg<=key, stateReg<=data, cnt<=0, go KEYEXP.
- KEYEXP (10 cycles): keyReg<=fwdExpand(keyReg, rcon[cnt]), cnt++. On the cycle where cnt=9: stateReg<=stateReg ^ fwdExpand(...) (AddRoundKey with rk10), cnt<=9, go ROUND.
- Forward expand: t = SubWord(RotWord(w3)) ^ rcon; w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
- rcon[i] in bits [31:24]: 01,02,04,08,10,20,40,80,1b,36 for i=0..9; low 24 bits zero.
- ROUND (10 cycles, cnt=9 down to 0): rk = invExpand(keyReg, rcon[cnt]); keyReg<=rk; stateReg<=InvShiftRows -> InvSubBytes -> ^rk -> InvMixColumns, InvMixColumns skipped when cnt=0. At cnt=0: dataOut<=result, validOut<=1, go DONE.
- Inverse expand: w3'=w3^w2, w2'=w2^w1, w1'=w1^w0, w0'=w0^SubWord(RotWord(w3'))^rcon.
- InvMixColumns uses GF(2^8) multiples 0e,0b,0d,09 built from xtime (shift left, ^1b on carry), all 8-bit.
- DONE: validOut=1, dataOut stable. On ack: validOut<=0, go IDLE. dataOut retains last value.
- validIn while ready=0 is ignored; no queuing.

## Timing
- Reset values: ready=1, validOut=0, dataOut=0; FSM=IDLE, cnt=0, keyReg/stateReg=0.
- rst mid-operation: immediate return to IDLE, in-flight block discarded, no validOut.
- Latency: accept at edge E; validOut rises after edge E+20 (10 KEYEXP + 10 ROUND).
- ready drops after edge E, returns after the edge that samples ack.
- Minimum block period 22 cycles (accept, 20 compute, ack cycle; IDLE cycle then accepts).
- ack held high continuously: block consumed on the first DONE cycle edge; ack outside DONE has no effect.
- validIn and ack both high in DONE: only ack acts; validIn must be re-presented in IDLE.
- cnt is 4 bits; never exceeds 9.

## Structure
- Package aes_pkg: forward and inverse S-box functions (case-based, no $readmemh), rcon table, xtime and gf_mul helpers, FSM state enum, AES_BLOCK_W=128.
- Sub-module aes_inv_round: combinational InvShiftRows/InvSubBytes/AddRoundKey/InvMixColumns with lastRound input; the key-step functions live in the top FSM module.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, data 69c4e0d86a7b0430d8cdb78070b4c55a -> dataOut 00112233445566778899aabbccddeeff, validOut exactly 20 cycles after accept.
- Internal check at end of KEYEXP: keyReg = 13111d7fe3944a17f307a78b4d2b30c5; at end of ROUND keyReg = original key.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, data 3925841d02dc09fbdc118597196a0b32 -> 3243f6a8885a308d313198a2e0370734.
- ack withheld 50 cycles -> validOut/dataOut stable, validIn pulses ignored, ready=0; ack -> IDLE next edge.
- rst asserted during ROUND cnt=5 -> outputs at reset values immediately; next block decrypts correctly.
- Back-to-back blocks with validIn held high and ack tied high -> accepts every 22 cycles, all outputs correct.
